// File: rtl/exec_opcode_monitor_pkg.sv
// Shared types and constants for the execute-stage opcode monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, completion opcode fields, TERNLOG default
// mask/match, and a helper that recognises the completion instruction.
package opcode_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // Test completion is signalled by a CSRRW: SYSTEM major opcode, funct3 001.
  localparam logic [6:0]  COMPL_OPCODE  = 7'b1110011;
  localparam logic [2:0]  COMPL_FUNCT3  = 3'b001;

  // Mask/match pair that the old TERNLOG watcher looked for.
  localparam logic [31:0] TERNLOG_MASK  = 32'h0600_007f;
  localparam logic [31:0] TERNLOG_MATCH = 32'h0400_007b;

  function automatic logic is_completion(input logic [31:0] insn);
    return (insn[6:0] == COMPL_OPCODE) && (insn[14:12] == COMPL_FUNCT3);
  endfunction

endpackage

// File: rtl/exec_opcode_monitor_if.sv
// Exec0 issue tap: valid, instruction word, PC and (optionally) operands.
// Latency: n/a (wires only).
// Backpressure: none; the tap is observe-only, there is no ready.
// Ports: valid, opcode[31:0], pc[31:0]; ra_operand/rb_operand[31:0] only when
// OPCODE_MON_OPERANDS_EN is defined. master = exec stage, slave = monitor.
interface exec_opcode_monitor_if;
  import opcode_mon_pkg::*;

  logic        valid;
  logic [31:0] opcode;
  logic [31:0] pc;
`ifdef OPCODE_MON_OPERANDS_EN
  logic [31:0] ra_operand;
  logic [31:0] rb_operand;
`endif

  modport master (
    output valid,
    output opcode,
    output pc
`ifdef OPCODE_MON_OPERANDS_EN
    , output ra_operand
    , output rb_operand
`endif
  );

  modport slave (
    input valid,
    input opcode,
    input pc
`ifdef OPCODE_MON_OPERANDS_EN
    , input ra_operand
    , input rb_operand
`endif
  );

endinterface

// File: rtl/exec_opcode_monitor_channel.sv
// One mask/match channel: compare, registered hit pulse, saturating hit counter.
// Latency: hit_o and count_o update 1 cycle after the issue cycle.
// Backpressure: none; every qualifying issue is counted.
// Ports: clk_i/rst_ni; clear_i zeroes state; issue_i = valid issue while
// monitoring; en_i/mask_i/match_i config; opcode_i word; hit_now_o is the
// combinational match (for capture priority); hit_o, count_o registered.
module opcode_mon_channel
  import opcode_mon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             issue_i,
  input  logic             en_i,
  input  logic [31:0]      mask_i,
  input  logic [31:0]      match_i,
  input  logic [31:0]      opcode_i,
  output logic             hit_now_o,
  output logic             hit_o,
  output logic [CNT_W-1:0] count_o
);

  logic             hit_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hit_now_o = issue_i && en_i && ((opcode_i & mask_i) == match_i);

  // Saturate at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (hit_now_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q <= 1'b0;
      cnt_q <= '0;
    end else if (clear_i) begin
      hit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hit_q <= hit_now_o;
      cnt_q <= cnt_d;
    end
  end

  assign hit_o   = hit_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/exec_opcode_monitor.sv
// Execute-stage opcode monitor: NUM_CH mask/match channels, first-hit capture,
// completion/drain/timeout FSM. Latency: hits, counts, capture 1 cycle after issue.
// Backpressure: none; passive tap, never stalls the pipeline.
// Ports: clk_i, rst_ni (async, active-low); arm_i, clear_i control; cfg_en_i,
// cfg_mask_i, cfg_match_i channel config; opcode_if exec0 issue tap (slave);
// hit_o, hit_count_o per channel; cap_* first-hit capture; state_o, done_o,
// timeout_o status. Optional: OPCODE_MON_OPERANDS_EN adds cap_ra_o/cap_rb_o.
module exec_opcode_monitor
  import opcode_mon_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int TO_W           = 32,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int DRAIN_CYCLES   = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    arm_i,
  input  logic                    clear_i,
  input  logic [NUM_CH-1:0]       cfg_en_i,
  input  logic [NUM_CH*32-1:0]    cfg_mask_i,
  input  logic [NUM_CH*32-1:0]    cfg_match_i,
  exec_opcode_monitor_if.slave    opcode_if,
  output logic [NUM_CH-1:0]       hit_o,
  output logic [NUM_CH*CNT_W-1:0] hit_count_o,
  output logic                    cap_valid_o,
  output logic [2:0]              cap_ch_o,
  output logic [31:0]             cap_pc_o,
  output logic [31:0]             cap_opcode_o,
`ifdef OPCODE_MON_OPERANDS_EN
  output logic [31:0]             cap_ra_o,
  output logic [31:0]             cap_rb_o,
`endif
  output logic [2:0]              state_o,
  output logic                    done_o,
  output logic                    timeout_o
);

  localparam int              DR_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [DR_W-1:0] dr_q, dr_d;

  logic              monitoring;
  logic [NUM_CH-1:0] hit_now;

  assign monitoring = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    opcode_mon_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .issue_i   (opcode_if.valid && monitoring),
      .en_i      (cfg_en_i[c]),
      .mask_i    (cfg_mask_i[32*c +: 32]),
      .match_i   (cfg_match_i[32*c +: 32]),
      .opcode_i  (opcode_if.opcode),
      .hit_now_o (hit_now[c]),
      .hit_o     (hit_o[c]),
      .count_o   (hit_count_o[CNT_W*c +: CNT_W])
    );
  end

  // Lowest-index hitting channel wins: scan downwards so the last write is c=0.
  logic       sel_any;
  logic [2:0] sel_ch;
  always_comb begin
    sel_any = 1'b0;
    sel_ch  = 3'd0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit_now[c]) begin
        sel_any = 1'b1;
        sel_ch  = 3'(c);
      end
    end
  end

  logic        cap_valid_q;
  logic [2:0]  cap_ch_q;
  logic [31:0] cap_pc_q, cap_opcode_q;
`ifdef OPCODE_MON_OPERANDS_EN
  logic [31:0] cap_ra_q, cap_rb_q;
`endif

  // Only the first hit after clear/reset is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_valid_q  <= 1'b0;
      cap_ch_q     <= '0;
      cap_pc_q     <= '0;
      cap_opcode_q <= '0;
`ifdef OPCODE_MON_OPERANDS_EN
      cap_ra_q     <= '0;
      cap_rb_q     <= '0;
`endif
    end else if (clear_i) begin
      cap_valid_q  <= 1'b0;
      cap_ch_q     <= '0;
      cap_pc_q     <= '0;
      cap_opcode_q <= '0;
`ifdef OPCODE_MON_OPERANDS_EN
      cap_ra_q     <= '0;
      cap_rb_q     <= '0;
`endif
    end else if (!cap_valid_q && sel_any) begin
      cap_valid_q  <= 1'b1;
      cap_ch_q     <= sel_ch;
      cap_pc_q     <= opcode_if.pc;
      cap_opcode_q <= opcode_if.opcode;
`ifdef OPCODE_MON_OPERANDS_EN
      cap_ra_q     <= opcode_if.ra_operand;
      cap_rb_q     <= opcode_if.rb_operand;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      to_q    <= '0;
      dr_q    <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      dr_q    <= dr_d;
    end
  end

  // In RUN the timeout wins over a completion issued on its last cycle; in
  // DRAIN drain expiry wins over the timeout.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    dr_d    = dr_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      to_d    = '0;
      dr_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            state_d = ST_RUN;
            to_d    = '0;
          end
        end
        ST_RUN: begin
          if (to_q == TO_LAST) begin
            state_d = ST_TIMEOUT;
          end else begin
            to_d = to_q + 1'b1;
            if (opcode_if.valid && is_completion(opcode_if.opcode)) begin
              state_d = ST_DRAIN;
              dr_d    = DR_LAST;
            end
          end
        end
        ST_DRAIN: begin
          if (dr_q == '0) begin
            state_d = ST_DONE;
          end else if (to_q == TO_LAST) begin
            state_d = ST_TIMEOUT;
          end else begin
            to_d = to_q + 1'b1;
            dr_d = dr_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cap_valid_o  = cap_valid_q;
  assign cap_ch_o     = cap_ch_q;
  assign cap_pc_o     = cap_pc_q;
  assign cap_opcode_o = cap_opcode_q;
`ifdef OPCODE_MON_OPERANDS_EN
  assign cap_ra_o     = cap_ra_q;
  assign cap_rb_o     = cap_rb_q;
`endif
  assign state_o      = state_q;
  assign done_o       = (state_q == ST_DONE);
  assign timeout_o    = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_exec_opcode_monitor.sv
// Bench for exec_opcode_monitor: directed scenarios plus random runs, every
// cycle compared against a cycle-count based reference model.
// Built with CNT_W=4, TIMEOUT_CYCLES=50, DRAIN_CYCLES=10.
module tb_exec_opcode_monitor;
  import opcode_mon_pkg::*;

  localparam int NCH  = 4;
  localparam int CW   = 4;
  localparam int T    = 50;
  localparam int D    = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, arm, clear;
  logic [NCH-1:0]    en;
  logic [NCH*32-1:0] mask, match;
  logic [NCH-1:0]    hit;
  logic [NCH*CW-1:0] cnts;
  logic              capv;
  logic [2:0]        capch;
  logic [31:0]       cappc, capop;
  logic [2:0]        st;
  logic              done, tmo;
`ifdef OPCODE_MON_OPERANDS_EN
  logic [31:0]       capra, caprb;
`endif

  exec_opcode_monitor_if bus ();

  exec_opcode_monitor #(
    .NUM_CH(NCH), .CNT_W(CW), .TO_W(32), .TIMEOUT_CYCLES(T), .DRAIN_CYCLES(D)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .arm_i        (arm),
    .clear_i      (clear),
    .cfg_en_i     (en),
    .cfg_mask_i   (mask),
    .cfg_match_i  (match),
    .opcode_if    (bus),
    .hit_o        (hit),
    .hit_count_o  (cnts),
    .cap_valid_o  (capv),
    .cap_ch_o     (capch),
    .cap_pc_o     (cappc),
    .cap_opcode_o (capop),
`ifdef OPCODE_MON_OPERANDS_EN
    .cap_ra_o     (capra),
    .cap_rb_o     (caprb),
`endif
    .state_o      (st),
    .done_o       (done),
    .timeout_o    (tmo)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: the state is derived from how many monitored cycles have
  // elapsed since arm (m_e) and when the completion was issued (m_ec).
  bit          m_armed, m_compl, m_capv;
  int          m_e, m_ec, m_capch;
  int          m_cnt [NCH];
  logic [3:0]  m_hit;
  logic [31:0] m_cappc, m_capop, m_capra, m_caprb;

  function automatic bit is_csrrw(input logic [31:0] op);
    return (op[6:0] == 7'h73) && (op[14:12] == 3'b001);
  endfunction

  // 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE, 4 TIMEOUT
  function automatic int m_state();
    if (!m_armed) return 0;
    if (m_compl && (m_ec + D <= T - 1)) begin
      if (m_e <= m_ec)     return 1;
      if (m_e <= m_ec + D) return 2;
      return 3;
    end
    if (m_e >= T) return 4;
    if (m_compl)  return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_compl = 0; m_e = 0; m_ec = 0;
    m_capv = 0; m_capch = 0; m_cappc = 0; m_capop = 0; m_capra = 0; m_caprb = 0;
    m_hit = '0;
    for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
  endtask

  task automatic model_step();
    int cur;
    cur = m_state();
    if (!rst_n || clear) begin
      model_reset();
      return;
    end
    m_hit = '0;
    if (bus.valid && (cur == 1 || cur == 2)) begin
      for (int c = 0; c < NCH; c++) begin
        if (en[c] && ((bus.opcode & mask[c*32 +: 32]) == match[c*32 +: 32])) begin
          m_hit[c] = 1'b1;
          if (m_cnt[c] < CMAX) m_cnt[c]++;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (!m_capv && m_hit[c]) begin
        m_capv = 1; m_capch = c; m_cappc = bus.pc; m_capop = bus.opcode;
`ifdef OPCODE_MON_OPERANDS_EN
        m_capra = bus.ra_operand; m_caprb = bus.rb_operand;
`endif
      end
    end
    if (cur == 0) begin
      if (arm) begin
        m_armed = 1; m_e = 0; m_compl = 0;
      end
    end else if (cur == 1 || cur == 2) begin
      if (cur == 1 && bus.valid && is_csrrw(bus.opcode) && m_e < T - 1) begin
        m_compl = 1; m_ec = m_e;
      end
      m_e++;
    end
  endtask

  task automatic compare_all();
    int s;
    s = m_state();
    check("state", 32'(st), 32'(s));
    check("done", 32'(done), 32'(s == 3));
    check("timeout", 32'(tmo), 32'(s == 4));
    check("hit", 32'(hit), 32'(m_hit));
    for (int c = 0; c < NCH; c++)
      check($sformatf("cnt%0d", c), 32'(cnts[c*CW +: CW]), 32'(m_cnt[c]));
    check("cap_valid", 32'(capv), 32'(m_capv));
    check("cap_ch", 32'(capch), 32'(m_capch));
    check("cap_pc", cappc, m_cappc);
    check("cap_opcode", capop, m_capop);
`ifdef OPCODE_MON_OPERANDS_EN
    check("cap_ra", capra, m_capra);
    check("cap_rb", caprb, m_caprb);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] op, input logic [31:0] pc);
    bus.valid  = v;
    bus.opcode = op;
    bus.pc     = pc;
`ifdef OPCODE_MON_OPERANDS_EN
    bus.ra_operand = $urandom;
    bus.rb_operand = $urandom;
`endif
  endtask

  function automatic logic [31:0] rnd_op(input bit allow_csr);
    logic [31:0] op;
    int          ch;
    op = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      ch = $urandom_range(0, NCH - 1);
      op = match[ch*32 +: 32] | (op & ~mask[ch*32 +: 32]);
    end
    if (allow_csr && $urandom_range(0, 9) == 0) begin
      op[6:0]   = 7'h73;
      op[14:12] = 3'b001;
    end else if (op[6:0] == 7'h73) begin
      op[6:0] = 7'h33;
    end
    return op;
  endfunction

  task automatic restart();
    drive(0, 0, 0);
    clear = 1; tick(); clear = 0;
    arm = 1; tick(); arm = 0;
  endtask

  initial begin
    rst_n = 0; arm = 0; clear = 0; en = '0; mask = '0; match = '0;
    drive(0, 0, 0);
    model_reset();
    #12;
    compare_all();
    check("rst_state", 32'(st), 32'd0);
    rst_n = 1;

    // Channel setup: ch0 TERNLOG, ch1 broader match of the same opcode,
    // ch2 exact word, ch3 matches any CSRRW.
    mask[0*32 +: 32]  = TERNLOG_MASK;  match[0*32 +: 32] = TERNLOG_MATCH;
    mask[1*32 +: 32]  = 32'h0000_007f; match[1*32 +: 32] = 32'h0000_007b;
    mask[2*32 +: 32]  = 32'hffff_ffff; match[2*32 +: 32] = 32'hdead_beef;
    mask[3*32 +: 32]  = 32'h0000_707f; match[3*32 +: 32] = 32'h0000_1073;
    en = 4'b0001;

    // Single ch0 hit.
    arm = 1; tick(); arm = 0;
    drive(1, 32'h0400_007b, 32'h8000_0010); tick();
    check("A_hit", 32'(hit), 32'h1);
    check("A_cnt0", 32'(cnts[3:0]), 32'd1);
    check("A_cap_pc", cappc, 32'h8000_0010);
    check("A_cap_ch", 32'(capch), 32'd0);
    drive(0, 0, 0); tick();
    check("A_hit_one_cycle", 32'(hit), 32'h0);

    // Two channels on one opcode; first capture retained.
    en = 4'b0011;
    drive(1, 32'h0400_007b, 32'h8000_0020); tick();
    check("B_cnt0", 32'(cnts[3:0]), 32'd2);
    check("B_cnt1", 32'(cnts[7:4]), 32'd1);
    check("B_cap_ch", 32'(capch), 32'd0);
    check("B_cap_first", cappc, 32'h8000_0010);

    // Saturation.
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h0400_007b, 32'h8000_0100 + 32'(i * 4)); tick();
    end
    check("C_sat0", 32'(cnts[3:0]), 32'd15);
    check("C_sat1", 32'(cnts[7:4]), 32'd15);

    // Completion, drain length, ignored second CSRRW.
    en = 4'b1001;
    drive(1, 32'h3400_1073, 32'h8000_0200); tick();
    check("D_drain", 32'(st), 32'd2);
    drive(1, 32'h3400_1073, 32'h8000_0204); tick();
    drive(0, 0, 0);
    for (int i = 0; i < 8; i++) tick();
    check("D_drain_last", 32'(st), 32'd2);
    tick();
    check("D_done_state", 32'(st), 32'd3);
    check("D_done", 32'(done), 32'd1);
    check("D_csr_hits", 32'(cnts[15:12]), 32'd2);

    // clear beats arm in DONE.
    clear = 1; arm = 1; tick(); clear = 0; arm = 0;
    check("E_idle", 32'(st), 32'd0);
    check("E_cnts", 32'(cnts), 32'd0);
    check("E_capv", 32'(capv), 32'd0);

    // Timeout with no completion.
    en = 4'b1111;
    arm = 1; tick(); arm = 0;
    for (int i = 0; i < 49; i++) begin
      drive(1, rnd_op(0), $urandom); tick();
    end
    check("F_run_last", 32'(st), 32'd1);
    drive(0, 0, 0); tick();
    check("F_timeout", 32'(tmo), 32'd1);

    // Drain ends on the timeout cycle: DONE wins.
    restart();
    for (int i = 0; i < 39; i++) tick();
    drive(1, 32'h3400_1073, 32'h8000_0300); tick(); drive(0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    check("G_done_wins", 32'(done), 32'd1);
    check("G_no_timeout", 32'(tmo), 32'd0);

    // One cycle later completion: the timeout lands mid-drain.
    restart();
    for (int i = 0; i < 40; i++) tick();
    drive(1, 32'h3400_1073, 32'h8000_0400); tick(); drive(0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    check("H_timeout_in_drain", 32'(tmo), 32'd1);

    // Async reset mid-drain.
    restart();
    drive(1, 32'h3400_1073, 32'h8000_0500); tick(); drive(0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all();
    check("I_async_cnt3", 32'(cnts[15:12]), 32'd0);
    tick();
    rst_n = 1;

    // Random runs.
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < NCH; c++) begin
        mask[c*32 +: 32]  = (r % 5 == 0 && c == 0) ? TERNLOG_MASK : ($urandom & 32'h0000_00ff);
        match[c*32 +: 32] = (r % 5 == 0 && c == 0) ? TERNLOG_MATCH : ($urandom & mask[c*32 +: 32]);
      end
      en = 4'($urandom);
      restart();
      for (int i = 0; i < 70; i++) begin
        clear = ($urandom_range(0, 63) == 0);
        arm   = ($urandom_range(0, 15) == 0);
        drive($urandom_range(0, 3) != 0, rnd_op(1), $urandom);
        tick();
      end
      clear = 0; arm = 0; drive(0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
